// File: rtl/lstm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lstm_pkg
// Brief    : Shared widths, scheduler state encoding and step-width helper.
// Revision : 1.0
// ============================================================================
package lstm_pkg;

    localparam int W    = 10;
    localparam int FEAT = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_BURST = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    // Counter width able to hold 0..max_steps inclusive.
    function automatic int calc_step_w(input int max_steps);
        return $clog2(max_steps + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_sample_buf.sv
`default_nettype none
// ============================================================================
// Module   : lstm_sample_buf
// Brief    : FEAT x W sample register file, one write port, async read.
// Revision : 1.0
// ============================================================================
module lstm_sample_buf #(
    parameter int W     = lstm_pkg::W,
    parameter int FEAT  = lstm_pkg::FEAT,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [W-1:0]     wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0] r_mem [FEAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FEAT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/lstm_step_sched.sv
`default_nettype none
// ============================================================================
// Module   : lstm_step_sched
// Brief    : Time-step scheduler feeding one lstm_unit and recirculating state.
// Revision : 1.0
// ============================================================================
module lstm_step_sched #(
    parameter int  W         = lstm_pkg::W,
    parameter int  FEAT      = lstm_pkg::FEAT,
    parameter int  MAX_STEPS = 301,
    parameter int  TIMEOUT   = 4096,
    localparam int STEP_W    = lstm_pkg::calc_step_w(MAX_STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] cfg_steps,
    input  logic [W-1:0]      init_a,
    input  logic [W-1:0]      init_c,
    input  logic              s_valid,
    input  logic [W-1:0]      s_data,
    output logic              s_ready,
    output logic              u_load,
    output logic [W-1:0]      u_x,
    output logic [W-1:0]      u_a_prev,
    output logic [W-1:0]      u_c_prev,
    input  logic              u_output_done,
    input  logic [W-1:0]      u_a_next,
    input  logic [W-1:0]      u_c_next,
    output logic              step_valid,
    output logic [STEP_W-1:0] step_idx,
    output logic [W-1:0]      step_a,
    output logic [W-1:0]      step_c,
    output logic              busy,
    output logic              seq_done,
    output logic              err
);
    import lstm_pkg::*;

    localparam int PTR_W = (FEAT > 1) ? $clog2(FEAT) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(FEAT - 1);
    localparam logic [WD_W-1:0]  c_wd_last  = WD_W'(TIMEOUT - 1);

    sched_state_t      r_state, w_next;
    logic [STEP_W-1:0] r_cfg_steps, r_step_cnt, r_step_idx;
    logic [W-1:0]      r_a, r_c, r_step_a, r_step_c, w_rd_data;
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [WD_W-1:0]   r_wdog;
    logic              r_err, r_step_valid, r_seq_done;
    logic              w_start_ok, w_accept, w_capture, w_timeout;
    logic              w_last_wr, w_last_rd, w_last_step;
    logic [STEP_W:0]   w_step_inc;

    assign w_start_ok  = start && (r_state == S_IDLE);
    assign w_accept    = s_valid && (r_state == S_FILL);
    assign w_capture   = u_output_done && (r_state == S_WAIT);
    assign w_timeout   = (r_state == S_WAIT) && !u_output_done && (r_wdog == c_wd_last);
    assign w_last_wr   = (r_wr_ptr == c_last_ptr);
    assign w_last_rd   = (r_rd_ptr == c_last_ptr);
    assign w_step_inc  = {1'b0, r_step_cnt} + (STEP_W + 1)'(1);
    assign w_last_step = (w_step_inc == {1'b0, r_cfg_steps});

    lstm_sample_buf #(
        .W     (W),
        .FEAT  (FEAT),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (reset),
        .we      (w_accept),
        .wr_ptr  (r_wr_ptr),
        .wr_data (s_data),
        .rd_ptr  (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (cfg_steps == '0) ? S_DONE : S_FILL;
            S_FILL:  if (w_accept && w_last_wr) w_next = S_BURST;
            S_BURST: if (w_last_rd) w_next = S_WAIT;
            S_WAIT: begin
                if (w_capture) begin
                    w_next = w_last_step ? S_DONE : S_FILL;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_steps  <= '0;
            r_step_cnt   <= '0;
            r_step_idx   <= '0;
            r_a          <= '0;
            r_c          <= '0;
            r_step_a     <= '0;
            r_step_c     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wdog       <= '0;
            r_err        <= 1'b0;
            r_step_valid <= 1'b0;
            r_seq_done   <= 1'b0;
        end else begin
            r_step_valid <= 1'b0;
            r_seq_done   <= (r_state == S_DONE);
            if (w_start_ok) begin
                r_cfg_steps <= cfg_steps;
                r_a         <= init_a;
                r_c         <= init_c;
                r_step_cnt  <= '0;
                r_err       <= 1'b0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_wdog      <= '0;
            end
            if (w_accept) begin
                r_wr_ptr <= w_last_wr ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (r_state == S_BURST) begin
                r_rd_ptr <= w_last_rd ? '0 : r_rd_ptr + PTR_W'(1);
                r_wdog   <= '0;
                // Unit result arriving mid-burst is a protocol violation; keep going.
                if (u_output_done) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_WAIT) begin
                if (w_capture) begin
                    r_a          <= u_a_next;
                    r_c          <= u_c_next;
                    r_step_a     <= u_a_next;
                    r_step_c     <= u_c_next;
                    r_step_idx   <= r_step_cnt;
                    r_step_valid <= 1'b1;
                    r_step_cnt   <= w_step_inc[STEP_W-1:0];
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + WD_W'(1);
                end
            end
        end
    end

    assign s_ready    = (r_state == S_FILL);
    assign u_load     = (r_state == S_BURST);
    assign u_x        = w_rd_data;
    assign u_a_prev   = r_a;
    assign u_c_prev   = r_c;
    assign step_valid = r_step_valid;
    assign step_idx   = r_step_idx;
    assign step_a     = r_step_a;
    assign step_c     = r_step_c;
    assign busy       = (r_state != S_IDLE);
    assign seq_done   = r_seq_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lstm_step_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lstm_step_sched
// Brief    : Directed self-checking bench for lstm_step_sched.
// Revision : 1.0
// ============================================================================
module tb_lstm_step_sched;

    localparam int W         = 10;
    localparam int FEAT      = 8;
    localparam int MAX_STEPS = 301;
    localparam int STEP_W    = 9;
    localparam int TIMEOUT   = 40;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [STEP_W-1:0] cfg_steps = '0;
    logic [W-1:0]      init_a = '0, init_c = '0;
    logic              s_valid = 1'b0;
    logic [W-1:0]      s_data = '0;
    logic              s_ready, u_load;
    logic [W-1:0]      u_x, u_a_prev, u_c_prev;
    logic              u_output_done = 1'b0;
    logic [W-1:0]      u_a_next = '0, u_c_next = '0;
    logic              step_valid, busy, seq_done, err;
    logic [STEP_W-1:0] step_idx;
    logic [W-1:0]      step_a, step_c;

    logic [W-1:0] samp [FEAT];
    int n_chk  = 0;
    int n_fail = 0;

    lstm_step_sched #(
        .W         (W),
        .FEAT      (FEAT),
        .MAX_STEPS (MAX_STEPS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_steps     (cfg_steps),
        .init_a        (init_a),
        .init_c        (init_c),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .u_load        (u_load),
        .u_x           (u_x),
        .u_a_prev      (u_a_prev),
        .u_c_prev      (u_c_prev),
        .u_output_done (u_output_done),
        .u_a_next      (u_a_next),
        .u_c_next      (u_c_next),
        .step_valid    (step_valid),
        .step_idx      (step_idx),
        .step_a        (step_a),
        .step_c        (step_c),
        .busy          (busy),
        .seq_done      (seq_done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [STEP_W-1:0] n, input logic [W-1:0] a, input logic [W-1:0] c);
        start = 1'b1; cfg_steps = n; init_a = a; init_c = c;
        tick();
        start = 1'b0;
    endtask

    task automatic fill(input bit gaps);
        for (int i = 0; i < FEAT; i++) begin
            chk("fill_ready", 32'(s_ready), 1);
            chk("fill_noload", 32'(u_load), 0);
            s_valid = 1'b1; s_data = samp[i];
            tick();
            s_valid = 1'b0;
            if (gaps && i < FEAT - 1) begin
                chk("gap_ready", 32'(s_ready), 1);
                chk("gap_noload", 32'(u_load), 0);
                tick();
            end
        end
    endtask

    task automatic burst(input logic [W-1:0] ea, input logic [W-1:0] ec);
        for (int j = 0; j < FEAT; j++) begin
            chk("burst_load", 32'(u_load), 1);
            chk("burst_x", 32'(u_x), 32'(samp[j]));
            chk("burst_a_prev", 32'(u_a_prev), 32'(ea));
            chk("burst_c_prev", 32'(u_c_prev), 32'(ec));
            chk("burst_ready", 32'(s_ready), 0);
            tick();
        end
        chk("wait_noload", 32'(u_load), 0);
    endtask

    task automatic finish_step(input logic [W-1:0] an, input logic [W-1:0] cn,
                               input int idx, input bit last, input int waitc);
        repeat (waitc) begin
            chk("wait_no_step", 32'(step_valid), 0);
            tick();
        end
        u_output_done = 1'b1; u_a_next = an; u_c_next = cn;
        tick();
        u_output_done = 1'b0;
        chk("step_valid", 32'(step_valid), 1);
        chk("step_idx", 32'(step_idx), 32'(idx));
        chk("step_a", 32'(step_a), 32'(an));
        chk("step_c", 32'(step_c), 32'(cn));
        chk("fb_a_prev", 32'(u_a_prev), 32'(an));
        chk("fb_c_prev", 32'(u_c_prev), 32'(cn));
        chk("seq_done_early", 32'(seq_done), 0);
        if (last) begin
            tick();
            chk("seq_done", 32'(seq_done), 1);
            chk("busy_drop", 32'(busy), 0);
            chk("step_valid_pulse", 32'(step_valid), 0);
            tick();
            chk("seq_done_pulse", 32'(seq_done), 0);
        end else begin
            chk("next_fill", 32'(s_ready), 1);
            chk("busy_mid", 32'(busy), 1);
        end
    endtask

    initial begin
        logic [W-1:0] ea, ec;

        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_load", 32'(u_load), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_a_prev", 32'(u_a_prev), 0);
        chk("rst_x", 32'(u_x), 0);
        reset = 1'b0;
        tick();

        // Single step
        samp[0] = 10'h387; samp[1] = 10'h381; samp[2] = 10'h307; samp[3] = 10'h043;
        samp[4] = 10'h002; samp[5] = 10'h026; samp[6] = 10'h3E1; samp[7] = 10'h342;
        do_start(9'd1, 10'h000, 10'h000);
        chk("t1_busy", 32'(busy), 1);
        fill(1'b0);
        burst(10'h000, 10'h000);
        finish_step(10'h155, 10'h2AA, 0, 1'b1, 2);

        // Three steps with an increment unit model; a stray start mid-fill
        do_start(9'd3, 10'd5, 10'd0);
        start = 1'b1; cfg_steps = 9'd1;
        tick();
        start = 1'b0;
        chk("ignored_start_ready", 32'(s_ready), 1);
        chk("ignored_start_busy", 32'(busy), 1);
        ea = 10'd5; ec = 10'd0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < FEAT; i++) samp[i] = W'(k * 37 + i * 11 + 1);
            fill(1'b0);
            burst(ea, ec);
            finish_step(ea + 10'd1, ec + 10'd2, k, k == 2, 1);
            ea = ea + 10'd1; ec = ec + 10'd2;
        end
        chk("t2_final_a", 32'(step_a), 8);
        chk("t2_final_c", 32'(step_c), 6);

        // Stalled upstream
        for (int i = 0; i < FEAT; i++) samp[i] = W'(10'h3FF - i * 5);
        do_start(9'd1, 10'h0F0, 10'h10F);
        fill(1'b1);
        burst(10'h0F0, 10'h10F);
        finish_step(10'h201, 10'h302, 0, 1'b1, 0);

        // Watchdog timeout
        for (int i = 0; i < FEAT; i++) samp[i] = W'(i * 3);
        do_start(9'd1, 10'd1, 10'd2);
        fill(1'b0);
        burst(10'd1, 10'd2);
        repeat (TIMEOUT - 1) tick();
        chk("to_err_pre", 32'(err), 0);
        chk("to_busy_pre", 32'(busy), 1);
        tick();
        chk("to_err", 32'(err), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_no_seq_done", 32'(seq_done), 0);
        tick();
        chk("to_no_seq_done2", 32'(seq_done), 0);
        chk("to_err_sticky", 32'(err), 1);

        // Zero-length sequence, which also clears err
        do_start(9'd0, 10'd9, 10'd9);
        chk("z_err_clear", 32'(err), 0);
        chk("z_busy", 32'(busy), 1);
        chk("z_noload", 32'(u_load), 0);
        chk("z_ready", 32'(s_ready), 0);
        chk("z_seq_early", 32'(seq_done), 0);
        tick();
        chk("z_seq_done", 32'(seq_done), 1);
        chk("z_noload2", 32'(u_load), 0);
        chk("z_busy_drop", 32'(busy), 0);
        tick();
        chk("z_seq_pulse", 32'(seq_done), 0);

        // Asynchronous reset while waiting on the unit
        for (int i = 0; i < FEAT; i++) samp[i] = W'(i + 100);
        do_start(9'd2, 10'h1F3, 10'h0AB);
        fill(1'b0);
        burst(10'h1F3, 10'h0AB);
        tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_a_prev", 32'(u_a_prev), 0);
        chk("ar_c_prev", 32'(u_c_prev), 0);
        chk("ar_step_a", 32'(step_a), 0);
        chk("ar_x", 32'(u_x), 0);
        chk("ar_load", 32'(u_load), 0);
        reset = 1'b0;
        tick();
        chk("ar_idle", 32'(busy), 0);
        chk("ar_no_seq_done", 32'(seq_done), 0);
        chk("ar_no_step", 32'(step_valid), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
